addr_unit: RTL and testbench

ADDR_UNIT -- requirements
Module: addr_unit

---
 rtl/addr_unit_pkg.sv | 16 +
 rtl/addr_unit_if.sv | 29 ++
 rtl/addr_unit_pc_reg.sv | 44 ++++
 rtl/addr_unit.sv | 107 ++++++++++
 tb/tb_addr_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/addr_unit_pkg.sv
// Shared types for the address unit: bus byte/word types, control encodings
// and the vector-fetch state enumeration.
package addr_unit_pkg;

  typedef logic [7:0]  data_t;
  typedef logic [15:0] addr_t;

  typedef enum logic {NOLOAD = 1'b0, LOAD = 1'b1} il_t;
  typedef enum logic [1:0] {PC_ADDR = 2'b00, A_ADDR = 2'b01} mm_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mw_t;

  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} fs_t;

  localparam data_t NOP_OP = 8'hEA;

endpackage

// File: rtl/addr_unit_if.sv
// Control and memory bus of the address unit. The master side is the
// control/memory environment; the slave side is the address unit itself.
interface addr_unit_if;
  import addr_unit_pkg::*;

  il_t   il;
  mm_t   mm;
  mw_t   mw;
  logic  pc_inc;
  logic  pc_ld;
  logic  op_ld_lo;
  logic  op_ld_hi;
  data_t data_in;
  addr_t addr;
  logic  we;
  data_t inst;
  logic  ready;

  modport master (
    output il, mm, mw, pc_inc, pc_ld, op_ld_lo, op_ld_hi, data_in,
    input  addr, we, inst, ready
  );

  modport slave (
    input  il, mm, mw, pc_inc, pc_ld, op_ld_lo, op_ld_hi, data_in,
    output addr, we, inst, ready
  );

endinterface

// File: rtl/addr_unit_pc_reg.sv
// Program counter: byte-wise vector load, full load, increment with wrap.
module pc_reg
  import addr_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  vec_lo_i,
  input  logic  vec_hi_i,
  input  logic  ld_i,
  input  logic  inc_i,
  input  data_t vec_i,
  input  addr_t ld_val_i,
  output addr_t pc_o
);

  addr_t pc_q;
  addr_t pc_d;

  // Next PC: vector bytes first, then load over increment over hold.
  always_comb begin
    pc_d = pc_q;
    if (vec_lo_i) begin
      pc_d[7:0] = vec_i;
    end else if (vec_hi_i) begin
      pc_d[15:8] = vec_i;
    end else if (ld_i) begin
      pc_d = ld_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 16'd1;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/addr_unit.sv
// Address unit: reset-vector fetch sequencer, operand address latches,
// instruction register and memory address mux.
module addr_unit
  import addr_unit_pkg::*;
#(
  parameter addr_t RESET_VEC = 16'hFFFC
) (
  input  logic         clk,
  input  logic         rst_n,
  addr_unit_if.slave   bus
);

  fs_t   state_q;
  logic  ready_q;
  data_t adl_q, adl_d;
  data_t adh_q, adh_d;
  data_t inst_q, inst_d;
  addr_t pc;
  addr_t op_addr;
  logic  run;

  assign run     = (state_q == RUN);
  assign op_addr = {adh_q, adl_q};

  // Vector fetch sequencer; ready is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VEC_LO;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        VEC_LO: begin
          state_q <= VEC_HI;
          ready_q <= 1'b0;
        end
        VEC_HI: begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
        RUN: begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= VEC_LO;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  pc_reg u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .vec_lo_i (state_q == VEC_LO),
    .vec_hi_i (state_q == VEC_HI),
    .ld_i     (run && bus.pc_ld),
    .inc_i    (run && bus.pc_inc),
    .vec_i    (bus.data_in),
    .ld_val_i (op_addr),
    .pc_o     (pc)
  );

  // Operand address latches and instruction register, active only in RUN.
  always_comb begin
    adl_d  = adl_q;
    adh_d  = adh_q;
    inst_d = inst_q;
    if (run) begin
      if (bus.op_ld_lo) adl_d = bus.data_in;
      if (bus.op_ld_hi) adh_d = bus.data_in;
      if (bus.il == LOAD) inst_d = bus.data_in;
    end
  end

  // Operand and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adl_q  <= '0;
      adh_q  <= '0;
      inst_q <= NOP_OP;
    end else begin
      adl_q  <= adl_d;
      adh_q  <= adh_d;
      inst_q <= inst_d;
    end
  end

  // Address mux and write enable; unknown mm encodings fall back to PC.
  always_comb begin
    bus.addr = RESET_VEC;
    bus.we   = 1'b0;
    case (state_q)
      VEC_LO:  bus.addr = RESET_VEC;
      VEC_HI:  bus.addr = RESET_VEC + 16'd1;
      RUN: begin
        bus.addr = (bus.mm == A_ADDR) ? op_addr : pc;
        bus.we   = (bus.mw == WRITE);
      end
      default: bus.addr = RESET_VEC;
    endcase
  end

  assign bus.inst  = inst_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_addr_unit.sv
// Bench for addr_unit: directed scenarios plus randomized RUN traffic, all
// checked against a cycle-level behavioural model of the unit.
module tb_addr_unit;
  import addr_unit_pkg::*;

  localparam logic [15:0] VEC = 16'hFFFC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  addr_unit_if bus ();

  addr_unit #(.RESET_VEC(16'hFFFC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:65535];
  logic       use_mem = 1'b0;
  logic [7:0] din = 8'h00;
  assign bus.data_in = use_mem ? mem[bus.addr] : din;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase 0 = fetching low vector byte, 1 = high byte, 2 = running.
  int         m_phase;
  logic [15:0] m_pc;
  logic [7:0]  m_adl, m_adh, m_inst;

  function automatic logic [15:0] exp_addr();
    if (m_phase == 0) return VEC;
    if (m_phase == 1) return 16'((int'(VEC) + 1) % 65536);
    return (bus.mm == A_ADDR) ? {m_adh, m_adl} : m_pc;
  endfunction

  function automatic logic exp_we();
    return (m_phase == 2) && (bus.mw == WRITE);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 16'h0000; m_adl = 8'h00; m_adh = 8'h00; m_inst = 8'hEA;
  endtask

  task automatic model_step();
    logic [7:0]  d;
    logic [15:0] npc;
    d = use_mem ? mem[exp_addr()] : din;
    if (m_phase == 0) begin
      m_pc = {m_pc[15:8], d}; m_phase = 1;
    end else if (m_phase == 1) begin
      m_pc = {d, m_pc[7:0]}; m_phase = 2;
    end else begin
      if (bus.il == LOAD) m_inst = d;
      if (bus.pc_ld) npc = {m_adh, m_adl};
      else if (bus.pc_inc) npc = 16'((int'(m_pc) + 1) % 65536);
      else npc = m_pc;
      m_pc = npc;
      if (bus.op_ld_lo) m_adl = d;
      if (bus.op_ld_hi) m_adh = d;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.il = NOLOAD; bus.mm = PC_ADDR; bus.mw = READ;
    bus.pc_inc = 1'b0; bus.pc_ld = 1'b0; bus.op_ld_lo = 1'b0; bus.op_ld_hi = 1'b0;
    din = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    bus.mw = WRITE; bus.il = LOAD;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.addr !== 16'hFFFC) $display("FAIL reset_addr got %h want fffc", bus.addr); else n_pass++;
    n_checks++; if (bus.we !== 1'b0) $display("FAIL reset_we got %b want 0", bus.we); else n_pass++;
    n_checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready); else n_pass++;
    n_checks++; if (bus.inst !== 8'hEA) $display("FAIL reset_inst got %h want ea", bus.inst); else n_pass++;
    n_checks++; if (dut.pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", dut.pc); else n_pass++;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (bus.addr !== 16'hFFFC || bus.ready !== 1'b0) $display("FAIL reset_hold addr %h ready %b want fffc 0", bus.addr, bus.ready); else n_pass++;
  endtask

  task automatic test_vector_fetch();
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    use_mem = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mw = WRITE; bus.il = LOAD; bus.pc_inc = 1'b1; bus.pc_ld = 1'b1;
    bus.op_ld_lo = 1'b1; bus.op_ld_hi = 1'b1;
    #1;
    n_checks++; if (bus.addr !== 16'hFFFC) $display("FAIL vec_lo_addr got %h want fffc", bus.addr); else n_pass++;
    n_checks++; if (bus.we !== 1'b0 || bus.ready !== 1'b0) $display("FAIL vec_lo_ctrl we %b ready %b want 0 0", bus.we, bus.ready); else n_pass++;
    step();
    @(negedge clk); #1;
    n_checks++; if (bus.addr !== 16'hFFFD) $display("FAIL vec_hi_addr got %h want fffd", bus.addr); else n_pass++;
    n_checks++; if (bus.we !== 1'b0 || bus.ready !== 1'b0) $display("FAIL vec_hi_ctrl we %b ready %b want 0 0", bus.we, bus.ready); else n_pass++;
    step();
    @(negedge clk);
    use_mem = 1'b0;
    idle();
    #1;
    n_checks++; if (bus.addr !== 16'h1234) $display("FAIL run_first_addr got %h want 1234", bus.addr); else n_pass++;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL run_first_ready got %b want 1", bus.ready); else n_pass++;
    n_checks++; if (bus.inst !== 8'hEA) $display("FAIL vec_inst_kept got %h want ea", bus.inst); else n_pass++;
    bus.mm = A_ADDR; #1;
    n_checks++; if (bus.addr !== 16'h0000) $display("FAIL vec_oper_kept got %h want 0000", bus.addr); else n_pass++;
    bus.mm = PC_ADDR;
    step();
  endtask

  task automatic test_fetch_inc();
    @(negedge clk);
    din = 8'hA9; bus.il = LOAD; bus.pc_inc = 1'b1;
    #1;
    n_checks++; if (bus.addr !== 16'h1234) $display("FAIL fetch_addr got %h want 1234", bus.addr); else n_pass++;
    step();
    @(negedge clk); idle(); #1;
    n_checks++; if (bus.inst !== 8'hA9) $display("FAIL fetch_inst got %h want a9", bus.inst); else n_pass++;
    n_checks++; if (bus.addr !== 16'h1235) $display("FAIL fetch_pc_inc got %h want 1235", bus.addr); else n_pass++;
    step();
  endtask

  task automatic test_operand();
    @(negedge clk); idle(); din = 8'h00; bus.op_ld_lo = 1'b1; step();
    @(negedge clk); idle(); din = 8'hC0; bus.op_ld_hi = 1'b1; step();
    @(negedge clk); idle(); bus.mm = A_ADDR; bus.mw = WRITE; bus.pc_ld = 1'b1;
    #1;
    n_checks++; if (bus.addr !== 16'hC000) $display("FAIL oper_addr got %h want c000", bus.addr); else n_pass++;
    n_checks++; if (bus.we !== 1'b1) $display("FAIL oper_we got %b want 1", bus.we); else n_pass++;
    step();
    @(negedge clk); idle(); #1;
    n_checks++; if (bus.addr !== 16'hC000) $display("FAIL oper_pc_ld got %h want c000", bus.addr); else n_pass++;
    n_checks++; if (bus.we !== 1'b0) $display("FAIL oper_we_read got %b want 0", bus.we); else n_pass++;
    step();
  endtask

  task automatic test_wrap();
    @(negedge clk); idle(); din = 8'hFF; bus.op_ld_lo = 1'b1; bus.op_ld_hi = 1'b1; step();
    @(negedge clk); idle(); bus.mm = A_ADDR; #1;
    n_checks++; if (bus.addr !== 16'hFFFF) $display("FAIL oper_both got %h want ffff", bus.addr); else n_pass++;
    bus.pc_ld = 1'b1; step();
    @(negedge clk); idle(); bus.pc_inc = 1'b1; #1;
    n_checks++; if (bus.addr !== 16'hFFFF) $display("FAIL wrap_pre got %h want ffff", bus.addr); else n_pass++;
    step();
    @(negedge clk); idle(); #1;
    n_checks++; if (bus.addr !== 16'h0000) $display("FAIL wrap_post got %h want 0000", bus.addr); else n_pass++;
    din = 8'h80; bus.op_ld_hi = 1'b1; step();
    @(negedge clk); idle(); din = 8'h00; bus.op_ld_lo = 1'b1; step();
    @(negedge clk); idle(); bus.pc_ld = 1'b1; bus.pc_inc = 1'b1; step();
    @(negedge clk); idle(); #1;
    n_checks++; if (bus.addr !== 16'h8000) $display("FAIL ld_over_inc got %h want 8000", bus.addr); else n_pass++;
    din = 8'h55; bus.op_ld_lo = 1'b1; bus.pc_ld = 1'b1; step();
    @(negedge clk); idle(); #1;
    n_checks++; if (bus.addr !== 16'h8000) $display("FAIL ld_pre_edge got %h want 8000", bus.addr); else n_pass++;
    bus.mm = A_ADDR; #1;
    n_checks++; if (bus.addr !== 16'h8055) $display("FAIL oper_after_ld got %h want 8055", bus.addr); else n_pass++;
    bus.mm = PC_ADDR;
    step();
  endtask

  task automatic test_reset_mid();
    mem[16'hFFFC] = 8'h78; mem[16'hFFFD] = 8'h56;
    @(negedge clk); idle(); use_mem = 1'b1; rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (bus.addr !== 16'hFFFC) $display("FAIL mid_vec_lo got %h want fffc", bus.addr); else n_pass++;
    step();
    @(negedge clk); #1;
    n_checks++; if (bus.addr !== 16'hFFFD) $display("FAIL mid_vec_hi got %h want fffd", bus.addr); else n_pass++;
    rst_n = 1'b0; model_reset(); #1;
    n_checks++; if (bus.addr !== 16'hFFFC) $display("FAIL mid_abort_addr got %h want fffc", bus.addr); else n_pass++;
    n_checks++; if (bus.ready !== 1'b0) $display("FAIL mid_abort_ready got %b want 0", bus.ready); else n_pass++;
    n_checks++; if (dut.pc !== 16'h0000) $display("FAIL mid_abort_pc got %h want 0000", dut.pc); else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (bus.addr !== 16'hFFFC) $display("FAIL mid_redo_lo got %h want fffc", bus.addr); else n_pass++;
    step();
    @(negedge clk); #1;
    n_checks++; if (bus.addr !== 16'hFFFD || bus.ready !== 1'b0) $display("FAIL mid_redo_hi addr %h ready %b want fffd 0", bus.addr, bus.ready); else n_pass++;
    step();
    @(negedge clk); use_mem = 1'b0; idle(); #1;
    n_checks++; if (bus.addr !== 16'h5678 || bus.ready !== 1'b1) $display("FAIL mid_redo_run addr %h ready %b want 5678 1", bus.addr, bus.ready); else n_pass++;
    step();
  endtask

  task automatic test_random();
    use_mem = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.il       = il_t'($urandom_range(0, 1));
      bus.mm       = mm_t'($urandom_range(0, 3));
      bus.mw       = mw_t'($urandom_range(0, 1));
      bus.pc_inc   = 1'($urandom_range(0, 1));
      bus.pc_ld    = ($urandom_range(0, 5) == 0);
      bus.op_ld_lo = 1'($urandom_range(0, 1));
      bus.op_ld_hi = 1'($urandom_range(0, 1));
      din          = 8'($urandom);
      #1;
      n_checks++; if (bus.addr !== exp_addr()) $display("FAIL rand_addr[%0d] got %h want %h", i, bus.addr, exp_addr()); else n_pass++;
      n_checks++; if (bus.we !== exp_we()) $display("FAIL rand_we[%0d] got %b want %b", i, bus.we, exp_we()); else n_pass++;
      n_checks++; if (bus.inst !== m_inst) $display("FAIL rand_inst[%0d] got %h want %h", i, bus.inst, m_inst); else n_pass++;
      n_checks++; if (bus.ready !== (m_phase == 2)) $display("FAIL rand_ready[%0d] got %b want %b", i, bus.ready, (m_phase == 2)); else n_pass++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vector_fetch();
    test_fetch_inc();
    test_operand();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
